// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the EX stage.
// Operands are latched on start; the result commits to HI/LO when the busy window ends.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        cancel,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_load;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  op_q;

    logic        op_valid;
    logic        op_is_mul;
    logic        finishing;
    logic        accept;
    logic        commit;
    logic        write_hi;
    logic        write_lo;

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_zero;

    // Control decode

    assign op_valid  = (op >= OP_MULT) && (op <= OP_DIVU);
    assign op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign finishing = (state == RUN) && (cnt == 4'd1);
    // A new start may land on the final edge of a running operation (back-to-back issue).
    assign accept    = start && !cancel && op_valid && ((state == IDLE) || finishing);
    assign busy      = (state == RUN);

    // FSM: state register

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next-state logic

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (finishing) state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: output logic

    always_comb begin
        commit   = 1'b0;
        write_hi = 1'b0;
        write_lo = 1'b0;
        cnt_load = op_is_mul ? MULT_LOAD : DIV_LOAD;
        case (state)
            IDLE: begin
                write_hi = mthi && !cancel && !accept;
                write_lo = mtlo && !cancel && !accept;
            end
            RUN: begin
                commit = finishing && !div_zero;
            end
            default: ;
        endcase
    end

    // Operand latch and countdown

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= 4'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            op_q <= 3'd0;
        end else if (accept) begin
            cnt  <= cnt_load;
            a_q  <= rs_data;
            b_q  <= rt_data;
            op_q <= op;
        end else if ((state == RUN) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Pending result, derived only from latched operands

    logic        signed_op;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;

    always_comb begin
        signed_op = (op_q == OP_MULT) || (op_q == OP_DIV);
        a_ext     = {(signed_op && a_q[31]) ? 32'hFFFF_FFFF : 32'd0, a_q};
        b_ext     = {(signed_op && b_q[31]) ? 32'hFFFF_FFFF : 32'd0, b_q};
        product   = a_ext * b_ext;

        // Sign-magnitude division: 0x80000000 / -1 naturally yields 0x80000000 rem 0.
        a_neg     = signed_op && a_q[31];
        b_neg     = signed_op && b_q[31];
        a_mag     = a_neg ? (32'd0 - a_q) : a_q;
        b_mag     = b_neg ? (32'd0 - b_q) : b_q;
        q_mag     = 32'd0;
        r_mag     = 32'd0;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quotient  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        remainder = a_neg ? (32'd0 - r_mag) : r_mag;

        div_zero  = ((op_q == OP_DIV) || (op_q == OP_DIVU)) && (b_q == 32'd0);
        if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
            res_hi = remainder;
            res_lo = quotient;
        end else begin
            res_hi = product[63:32];
            res_lo = product[31:0];
        end
    end

    // Architectural HI/LO

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (commit) begin
            hi <= res_hi;
            lo <= res_lo;
        end else begin
            if (write_hi) hi <= rs_data;
            if (write_lo) lo <= rs_data;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: reset, arithmetic, timing, cancel and priority.
module tb_mult_div_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic        mthi;
    logic        mtlo;
    logic        cancel;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .cancel  (cancel),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start   = 1'b0;
        op      = 3'd0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        cancel  = 1'b0;
        rs_data = 32'd0;
        rt_data = 32'd0;
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        mthi = 1'b1; rs_data = h; tick();
        mthi = 1'b0; mtlo = 1'b1; rs_data = l; tick();
        idle_inputs();
    endtask

    // Issue one operation, measure busy length, check HI/LO stay stable until commit.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cycles;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        logic leaked;
        old_hi = hi;
        old_lo = lo;
        leaked = 1'b0;
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        tick();
        idle_inputs();
        cycles = 0;
        while (busy && cycles < 40) begin
            if (hi !== old_hi || lo !== old_lo) leaked = 1'b1;
            tick();
            cycles++;
        end
        tests_run++;
        if (cycles !== n) begin
            tests_failed++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, cycles, n);
        end
        tests_run++;
        if (leaked !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s hilo_stable_while_busy: got changed expected stable", name);
        end
        tests_run++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            tests_failed++;
            $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h",
                     name, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        #12;
        tests_run++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
        reset_n = 1'b1;
        tick();
        preload(32'hAAAA_0001, 32'hBBBB_0002);
        start = 1'b1; op = OP_MULT; rs_data = 32'd3; rt_data = 32'd4;
        tick();
        idle_inputs();
        tick();
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_op_async: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
        #3 reset_n = 1'b1;
        repeat (8) tick();
        tests_run++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_no_late_commit: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
    endtask

    task automatic test_mult();
        run_op("mult_neg2x3",  OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu_neg2x3", OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    endtask

    task automatic test_div();
        run_op("div_m7_2",     OP_DIV,  32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_fff9_2",  OP_DIVU, 32'hFFFF_FFF9, 32'd2,         10, 32'h0000_0001, 32'h7FFF_FFFC);
        run_op("div_overflow", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        run_op("div_7_m2",     OP_DIV,  32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    endtask

    task automatic test_div_zero();
        mthi = 1'b1; mtlo = 1'b1; rs_data = 32'h11;
        tick();
        mtlo = 1'b1; mthi = 1'b0; rs_data = 32'h22;
        tick();
        idle_inputs();
        tests_run++;
        if (hi !== 32'h11 || lo !== 32'h22) begin
            tests_failed++;
            $display("FAIL mthi_mtlo_preload: got hi=%h lo=%h expected hi=00000011 lo=00000022", hi, lo);
        end
        run_op("divu_by_zero", OP_DIVU, 32'h1234_5678, 32'd0, 10, 32'h11, 32'h22);
        run_op("div_by_zero",  OP_DIV,  32'hFFFF_0000, 32'd0, 10, 32'h11, 32'h22);
    endtask

    task automatic test_cancel();
        int cycles;
        start = 1'b1; cancel = 1'b1; op = OP_MULT; rs_data = 32'd9; rt_data = 32'd9;
        tick();
        idle_inputs();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_cancel_busy: got %b expected 0", busy);
        end
        repeat (6) tick();
        tests_run++;
        if (hi !== 32'h11 || lo !== 32'h22) begin
            tests_failed++;
            $display("FAIL start_cancel_hilo: got hi=%h lo=%h expected hi=00000011 lo=00000022", hi, lo);
        end
        mthi = 1'b1; mtlo = 1'b1; cancel = 1'b1; rs_data = 32'h99;
        tick();
        idle_inputs();
        tests_run++;
        if (hi !== 32'h11 || lo !== 32'h22) begin
            tests_failed++;
            $display("FAIL mthi_cancel: got hi=%h lo=%h expected hi=00000011 lo=00000022", hi, lo);
        end
        start = 1'b1; op = OP_MULT; rs_data = 32'd5; rt_data = 32'd6;
        tick();
        idle_inputs();
        tick();
        mthi = 1'b1; mtlo = 1'b1; rs_data = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        cycles = 0;
        while (busy && cycles < 20) begin
            tick();
            cycles++;
        end
        tests_run++;
        if (hi !== 32'd0 || lo !== 32'd30) begin
            tests_failed++;
            $display("FAIL mthi_during_run: got hi=%h lo=%h expected hi=00000000 lo=0000001e", hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        preload(32'h0000_0055, 32'h0000_0066);
        start = 1'b1; op = OP_MULT; rs_data = 32'd5; rt_data = 32'd6;
        tick();
        idle_inputs();
        repeat (4) tick();
        start = 1'b1; op = OP_MULT; rs_data = 32'd2; rt_data = 32'd2;
        tick();
        idle_inputs();
        tests_run++;
        if (busy !== 1'b1 || hi !== 32'd0 || lo !== 32'd30) begin
            tests_failed++;
            $display("FAIL b2b_first_commit: got busy=%b hi=%h lo=%h expected busy=1 hi=0 lo=1e",
                     busy, hi, lo);
        end
        cycles = 0;
        while (busy && cycles < 20) begin
            tick();
            cycles++;
        end
        tests_run++;
        if (cycles !== 5 || lo !== 32'd4 || hi !== 32'd0) begin
            tests_failed++;
            $display("FAIL b2b_second: got cycles=%0d hi=%h lo=%h expected cycles=5 hi=0 lo=4",
                     cycles, hi, lo);
        end
        preload(32'h0000_0055, 32'h0000_0066);
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = OP_MULTU; rs_data = 32'd7; rt_data = 32'd1;
        tick();
        idle_inputs();
        tests_run++;
        if (busy !== 1'b1 || hi !== 32'h55 || lo !== 32'h66) begin
            tests_failed++;
            $display("FAIL start_beats_mthi: got busy=%b hi=%h lo=%h expected busy=1 hi=55 lo=66",
                     busy, hi, lo);
        end
        cycles = 0;
        while (busy && cycles < 20) begin
            tick();
            cycles++;
        end
        tests_run++;
        if (hi !== 32'd0 || lo !== 32'd7) begin
            tests_failed++;
            $display("FAIL start_beats_mthi_result: got hi=%h lo=%h expected hi=0 lo=7", hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_cancel();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle HI/LO multiply/divide unit in the EX stage of the five-stage pipeline. It consumes the decoder's multiply/divide controls (operation select, start, mthi/mtlo) together with the forwarded rs/rt operands. It runs multiply for 5 cycles and divide for 10 cycles, then commits results into the architectural HI/LO registers. It exports `busy` so the hazard unit can stall later multiply/divide instructions held in ID.

## Interface
- `MULT_CYCLES`, default 5: busy duration of mult/multu, in cycles.
- `DIV_CYCLES`, default 10: busy duration of div/divu, in cycles.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: reset is asynchronous and active-low.
- `start` input 1: begin the operation selected by `op`; sampled at the rising edge.
- `op` input 3: operation select. 3'd1 = mult, 3'd2 = multu, 3'd3 = div, 3'd4 = divu. Any other value is a no-op.
- `mthi` input 1: write `rs_data` into HI.
- `mtlo` input 1: write `rs_data` into LO.
- `cancel` input 1: the EX instruction is being flushed by an exception or interrupt. Suppresses `start`, `mthi` and `mtlo` in the same cycle.
- `rs_data` input 32: operand A (dividend / multiplicand), forwarded value.
- `rt_data` input 32: operand B (divisor / multiplier), forwarded value.
- `busy` output 1: an operation is in flight.
- `hi` output 32: architectural HI register.
- `lo` output 32: architectural LO register.

## Operation
- **States:** IDLE and RUN. A 4-bit down-counter `cnt` and a pending result {res_hi, res_lo} are internal.
- **Reset (any time, including mid-operation):**
  - `hi` = 0, `lo` = 0, `busy` = 0, `cnt` = 0, state = IDLE.
  - Any pending result is discarded.
- **Starting an operation (IDLE):** a start is accepted when `start` = 1, `cancel` = 0, and `op` ∈ {1..4}.
  - Operands are latched and the result is computed from those latched values.
  - `cnt` ← MULT_CYCLES or DIV_CYCLES, and state → RUN.
- **Priority in IDLE:** an accepted start wins over a simultaneous `mthi`/`mtlo`.
- **mthi/mtlo in IDLE:** without an accepted start, `mthi` → `hi` ← `rs_data` and `mtlo` → `lo` ← `rs_data`. Both may fire in the same cycle.
- **RUN:**
  - `cnt` decrements each cycle.
  - On the edge where `cnt` = 1: `hi`/`lo` ← pending result, state → IDLE.
  - `start`, `mthi` and `mtlo` are ignored while in RUN; the hazard unit guarantees they are not issued.
  - `cancel` does not abort an operation already in RUN.
- **`busy`** = (state == RUN), registered.
- **Arithmetic results:**
  - mult: signed 32×32 → 64, {hi, lo} = product.
  - multu: unsigned 32×32 → 64, {hi, lo} = product.
  - div: signed. lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - div special case: 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
  - divu: unsigned, lo = quotient, hi = remainder.
  - Divisor = 0 (div or divu): the operation still occupies DIV_CYCLES, and `hi`/`lo` keep their prior values.
- **Outputs:** `hi`/`lo` always show the committed values. They never show intermediate or pending results, so mfhi/mflo issued after `busy` falls read the new result.

## Timing
- Start accepted at edge T0:
  - `busy` = 1 from T0 until edge T0+N, where N = MULT_CYCLES or DIV_CYCLES.
  - At edge T0+N, `hi`/`lo` update and `busy` returns to 0.
  - `busy` is therefore high for exactly N cycles.
- **Hazard unit stall condition:** the ID multiply/divide instruction stalls while (`start` | `busy`). `start` is combinational from EX; `busy` covers the following N cycles.
- **Back-to-back starts:** the earliest new start is at edge T0+N, the same edge on which `busy` falls. It is accepted, and the previous result commits on that edge.
- **mthi/mtlo latency:** the write is visible on `hi`/`lo` one edge after assertion.
- **Combinational paths:** none from inputs to outputs.

## Test plan
- **Reset mid-operation:**
  - Stimulus: `reset_n` = 0 at power-up, then release; start mult 3 × 4; pull `reset_n` low at cycle 2 of RUN.
  - Required: `busy` = 0, `hi`/`lo` = 0 immediately (asynchronously); no commit occurs afterwards.
- **Signed multiply:**
  - Stimulus: mult with rs = 0xFFFFFFFE (−2), rt = 0x00000003.
  - Required: `busy` high for exactly 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA.
  - Also: multu with the same operands gives hi = 0x00000002, lo = 0xFFFFFFFA.
- **Signed and unsigned divide:**
  - div −7 / 2: `busy` for 10 cycles, then lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - divu 0xFFFFFFF9 / 2: lo = 0x7FFFFFFC, hi = 1.
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- **Divide by zero:**
  - Stimulus: preload hi = 0x11, lo = 0x22 via mthi/mtlo; then divu x / 0.
  - Required: `busy` for 10 cycles; afterwards hi = 0x11, lo = 0x22.
- **Cancel and ignored writes:**
  - `start` together with `cancel` → no busy, `hi`/`lo` unchanged.
  - mthi with `cancel` → `hi` unchanged.
  - `mthi` asserted during RUN → ignored; the final hi equals the computed result.
- **Back-to-back and simultaneous events:**
  - Stimulus: start mult 5 × 6, then start a new mult 2 × 2 exactly on the edge where `busy` falls.
  - Required: lo = 30 committed on that edge; `busy` stays high 5 more cycles; then lo = 4.
  - Separately: `start` + `mthi` in the same IDLE cycle → only the start takes effect.
